// File: rtl/seq_uart_tx.sv
// seq_uart_tx: sequencer-bus UART transmitter (8N1, or 8E1 with parity build).
//
// Instructions arrive on inst, qualified by inst_en, and execute at the rising
// edge where inst_en=1:
//   4'h0 NOP, 4'h1 WR imm -> holding register, 4'h2 CLR overrun,
//   4'h3 DIV imm -> bit divisor (only while idle with empty holding register),
//   4'h4..4'hF ignored.
//
// Ports:
//   clock    system clock, all state on rising edge
//   reset    asynchronous active-low reset
//   inst     [11:8] opcode, [7:0] immediate
//   inst_en  instruction valid this cycle
//   tx       serial line, idle high, LSB first, driven from a flop
//   status   {5'b0, overrun, hold_full, busy}
//
// Build option: define SEQ_UART_TX_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit.
module seq_uart_tx #(
    parameter logic [7:0] DEFAULT_DIV = 8'd15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic        tx,
    output logic [7:0]  status
);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StStart  = 3'd1;
    localparam logic [2:0] StData   = 3'd2;
    localparam logic [2:0] StStop   = 3'd4;
`ifdef SEQ_UART_TX_PARITY_EN
    localparam logic [2:0] StParity = 3'd3;
`endif

    logic [2:0] state_q, state_d;
    logic [7:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] div_q, div_d;
    logic [7:0] hold_q, hold_d;
    logic       hold_full_q, hold_full_d;
    logic       overrun_q, overrun_d;
    logic       tx_q, tx_d;
`ifdef SEQ_UART_TX_PARITY_EN
    logic       par_q, par_d;
`endif

    logic [3:0] opcode;
    logic [7:0] imm;
    logic       wr, clr, div_wr;
    logic       bit_end;
    logic       xfer;

    assign opcode  = inst[11:8];
    assign imm     = inst[7:0];
    assign wr      = inst_en && (opcode == 4'h1);
    assign clr     = inst_en && (opcode == 4'h2);
    assign div_wr  = inst_en && (opcode == 4'h3);
    assign bit_end = (tick_q == div_q);

    // Frame sequencing; xfer moves the holding register into the shifter.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef SEQ_UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        xfer    = 1'b0;

        if (state_q != StIdle) begin
            tick_d = bit_end ? 8'd0 : tick_q + 8'd1;
        end

        case (state_q)
            StIdle: begin
                if (hold_full_q) xfer = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = 3'd0;
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
`ifdef SEQ_UART_TX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef SEQ_UART_TX_PARITY_EN
            StParity: begin
                if (bit_end) state_d = StStop;
            end
`endif
            StStop: begin
                // A waiting byte starts its frame with no idle gap.
                if (bit_end) begin
                    if (hold_full_q) xfer = 1'b1;
                    else             state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (xfer) begin
            state_d = StStart;
            tick_d  = 8'd0;
            shift_d = hold_q;
`ifdef SEQ_UART_TX_PARITY_EN
            par_d   = ^hold_q;
`endif
        end
    end

    // Holding register, overrun flag and divisor.
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        overrun_d   = overrun_q;
        div_d       = div_q;

        if (xfer) hold_full_d = 1'b0;
        if (clr)  overrun_d   = 1'b0;
        if (wr) begin
            // A write in the same cycle as a transfer refills the freed slot.
            if (hold_full_q && !xfer) begin
                overrun_d = 1'b1;
            end else begin
                hold_d      = imm;
                hold_full_d = 1'b1;
            end
        end
        if (div_wr && (state_q == StIdle) && !hold_full_q) div_d = imm;
    end

    // Line level for the cycle after this edge, so tx comes straight off a flop.
    always_comb begin
        case (state_d)
            StStart:  tx_d = 1'b0;
            StData:   tx_d = shift_d[0];
`ifdef SEQ_UART_TX_PARITY_EN
            StParity: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            tick_q      <= 8'd0;
            bit_q       <= 3'd0;
            shift_q     <= 8'd0;
            div_q       <= DEFAULT_DIV;
            hold_q      <= 8'd0;
            hold_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            tx_q        <= 1'b1;
`ifdef SEQ_UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            div_q       <= div_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            overrun_q   <= overrun_d;
            tx_q        <= tx_d;
`ifdef SEQ_UART_TX_PARITY_EN
            par_q       <= par_d;
`endif
        end
    end

    assign tx     = tx_q;
    assign status = {5'b0, overrun_q, hold_full_q, (state_q != StIdle)};

endmodule

// File: tb/tb_seq_uart_tx.sv
// Testbench for seq_uart_tx: table of directed vectors, hand-written frame
// sequences and a randomized run against a line-sample queue model.
module tb_seq_uart_tx;

`ifdef SEQ_UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] inst = 12'h000;
    logic        inst_en = 1'b0;
    logic        tx;
    logic [7:0]  status;

    always #5 clock = ~clock;

    seq_uart_tx dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (inst),
        .inst_en (inst_en),
        .tx      (tx),
        .status  (status)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: queue of line levels still to appear, one entry per clock.
    bit         line_q[$];
    logic [7:0] m_hold;
    logic [7:0] m_div;
    logic       m_hf;
    logic       m_ov;

    function automatic logic m_tx();
        return (line_q.size() == 0) ? 1'b1 : line_q[0];
    endfunction

    function automatic logic [7:0] m_status();
        return {5'b0, m_ov, m_hf, line_q.size() != 0};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        line_q.delete();
        m_hold = 8'h00;
        m_hf   = 1'b0;
        m_ov   = 1'b0;
        m_div  = 8'd15;
    endtask

    task automatic push_frame(input logic [7:0] d);
        logic b;
        for (int k = 0; k < NBITS; k++) begin
            if (k == 0)                 b = 1'b0;
            else if (k <= 8)            b = d[k-1];
            else if (k == NBITS - 1)    b = 1'b1;
            else                        b = ^d;
            for (int r = 0; r <= int'(m_div); r++) line_q.push_back(b);
        end
    endtask

    task automatic model_edge(input logic [3:0] op, input logic [7:0] imm, input logic en);
        bit xfer, idle_pre, hf_pre;
        hf_pre   = m_hf;
        idle_pre = (line_q.size() == 0);
        xfer     = m_hf && (line_q.size() <= 1);
        if (line_q.size() > 1) begin
            void'(line_q.pop_front());
        end else begin
            line_q.delete();
            if (xfer) push_frame(m_hold);
        end
        if (xfer) m_hf = 1'b0;
        if (en) begin
            case (op)
                4'h1: begin
                    if (hf_pre && !xfer) m_ov = 1'b1;
                    else begin
                        m_hold = imm;
                        m_hf   = 1'b1;
                    end
                end
                4'h2: m_ov = 1'b0;
                4'h3: if (idle_pre && !hf_pre) m_div = imm;
                default: ;
            endcase
        end
    endtask

    // One clock: drive at negedge, update model at the edge, sample 1 ns later.
    task automatic step(input logic [3:0] op, input logic [7:0] imm, input logic en);
        @(negedge clock);
        inst    = {op, imm};
        inst_en = en;
        @(posedge clock);
        model_edge(op, imm, en);
        #1;
        check("model_tx", {7'b0, tx}, {7'b0, m_tx()});
        check("model_status", status, m_status());
        inst_en = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0] op;
        logic [7:0] imm;
        logic       en;
        logic       exp_tx;
        logic [7:0] exp_st;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [3:0] op, input logic [7:0] imm, input logic en,
                       input logic exp_tx, input logic [7:0] exp_st);
        vec_t v;
        v.op = op; v.imm = imm; v.en = en; v.exp_tx = exp_tx; v.exp_st = exp_st;
        tbl.push_back(v);
    endtask

    initial begin
        int cnt;
        int r;
        logic [10:0] a5_line;
        logic        samples[$];

        // Directed table: divisor 0 so every bit lasts one clock.
        add(4'h0, 8'h00, 1'b1, 1'b1, 8'h00);
        add(4'h5, 8'hFF, 1'b1, 1'b1, 8'h00);
        add(4'hF, 8'h12, 1'b1, 1'b1, 8'h00);
        add(4'h1, 8'h55, 1'b0, 1'b1, 8'h00);  // WR without inst_en
        add(4'h3, 8'h00, 1'b1, 1'b1, 8'h00);  // DIV 0 while idle
        add(4'h1, 8'h01, 1'b1, 1'b1, 8'h02);
        add(4'h0, 8'h00, 1'b0, 1'b0, 8'h01);  // transfer, start bit
        add(4'h0, 8'h00, 1'b0, 1'b1, 8'h01);  // d0
        add(4'h0, 8'h00, 1'b0, 1'b0, 8'h01);  // d1
        add(4'h1, 8'h80, 1'b1, 1'b0, 8'h03);  // d2
        add(4'h1, 8'hFF, 1'b1, 1'b0, 8'h07);  // d3, overrun
        add(4'h2, 8'h00, 1'b1, 1'b0, 8'h03);  // d4, clear
        add(4'h0, 8'h00, 1'b0, 1'b0, 8'h03);  // d5
        add(4'h0, 8'h00, 1'b0, 1'b0, 8'h03);  // d6
        add(4'h0, 8'h00, 1'b0, 1'b0, 8'h03);  // d7
`ifdef SEQ_UART_TX_PARITY_EN
        add(4'h0, 8'h00, 1'b0, 1'b1, 8'h03);  // parity of 8'h01
`endif
        add(4'h0, 8'h00, 1'b0, 1'b1, 8'h03);  // stop
        add(4'h0, 8'h00, 1'b0, 1'b0, 8'h01);  // back-to-back start
        for (int i = 0; i < 7; i++) add(4'h0, 8'h00, 1'b0, 1'b0, 8'h01);
        add(4'h0, 8'h00, 1'b0, 1'b1, 8'h01);  // d7 of 8'h80
`ifdef SEQ_UART_TX_PARITY_EN
        add(4'h0, 8'h00, 1'b0, 1'b1, 8'h01);  // parity of 8'h80
`endif
        add(4'h0, 8'h00, 1'b0, 1'b1, 8'h01);  // stop
        add(4'h0, 8'h00, 1'b0, 1'b1, 8'h00);  // idle

        model_reset();
        do_reset();
        #1;
        check("reset_tx", {7'b0, tx}, 8'h01);
        check("reset_status", status, 8'h00);
        for (int i = 0; i < 50; i++) step(4'h0, 8'h00, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].op, tbl[i].imm, tbl[i].en);
            check($sformatf("vec%0d_tx", i), {7'b0, tx}, {7'b0, tbl[i].exp_tx});
            check($sformatf("vec%0d_status", i), status, tbl[i].exp_st);
        end

        // Frame of 8'hA5 at default divisor; a DIV mid-frame must be ignored.
`ifdef SEQ_UART_TX_PARITY_EN
        a5_line = 11'b10101001010;
`else
        a5_line = 11'b01101001010;
`endif
        do_reset();
        step(4'h1, 8'hA5, 1'b1);
        check("a5_hold", status, 8'h02);
        step(4'h0, 8'h00, 1'b0);
        check("a5_fall", {7'b0, tx}, 8'h00);
        samples.delete();
        samples.push_back(tx);
        cnt = 1;
        for (int i = 0; i < 400 && status[0]; i++) begin
            if (i == 40) step(4'h3, 8'h00, 1'b1);
            else         step(4'h0, 8'h00, 1'b0);
            if (status[0]) begin
                cnt++;
                samples.push_back(tx);
            end
        end
        check("a5_busy_len", cnt[7:0], 8'(NBITS * 16));
        for (int b = 0; b < NBITS; b++) begin
            if (b * 16 + 8 < samples.size())
                check($sformatf("a5_bit%0d", b), {7'b0, samples[b*16+8]}, {7'b0, a5_line[b]});
            else
                check($sformatf("a5_bit%0d_missing", b), 8'h00, 8'h01);
        end
        check("a5_end", status, 8'h00);

        // Back-to-back frames at divisor 3.
        do_reset();
        step(4'h3, 8'h03, 1'b1);
        step(4'h1, 8'h01, 1'b1);
        step(4'h0, 8'h00, 1'b0);
        step(4'h0, 8'h00, 1'b0);
        step(4'h1, 8'h02, 1'b1);
        check("b2b_second_wr", status, 8'h03);
        cnt = 3;
        for (int i = 0; i < 200 && status[0]; i++) begin
            step(4'h0, 8'h00, 1'b0);
            if (status[0]) cnt++;
            if (cnt == NBITS * 4 + 1 && status[0]) begin
                check("b2b_second_start_st", status, 8'h01);
                check("b2b_second_start_tx", {7'b0, tx}, 8'h00);
            end
        end
        check("b2b_len", cnt[7:0], 8'(2 * NBITS * 4));
        check("b2b_end", status, 8'h00);

        // Three writes in consecutive cycles: the third overruns.
        do_reset();
        step(4'h1, 8'h11, 1'b1);
        step(4'h1, 8'h22, 1'b1);
        step(4'h1, 8'h33, 1'b1);
        check("ovr_status", status, 8'h07);
        check("ovr_bits", {6'b0, status[2:1]}, 8'h03);
        step(4'h2, 8'h00, 1'b1);
        check("clr_status", status, 8'h03);
        cnt = 3;
        for (int i = 0; i < 600 && status[0]; i++) begin
            step(4'h0, 8'h00, 1'b0);
            if (status[0]) cnt++;
        end
        check("ovr_len", cnt[15:0], 16'(2 * NBITS * 16) );
        check("ovr_end", status, 8'h00);

        // Reset pulse in the middle of the data bits.
        step(4'h1, 8'h5A, 1'b1);
        for (int i = 0; i < 40; i++) step(4'h0, 8'h00, 1'b0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_mid_tx", {7'b0, tx}, 8'h01);
        check("rst_mid_status", status, 8'h00);
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 20; i++) step(4'h0, 8'h00, 1'b0);
        check("rst_after_tx", {7'b0, tx}, 8'h01);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 4)       step(4'h1, 8'($urandom), 1'b1);
            else if (r < 6)  step(4'h2, 8'($urandom), 1'b1);
            else if (r < 9)  step(4'h3, 8'($urandom_range(0, 3)), 1'b1);
            else if (r < 11) step(4'($urandom_range(4, 15)), 8'($urandom), 1'b1);
            else if (r < 13) step(4'($urandom_range(1, 3)), 8'($urandom), 1'b0);
            else             step(4'h0, 8'h00, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
